// File: rtl/spi_flash_reader.sv
// SPI NOR flash read engine (03h/0Bh/3Bh/6Bh) with valid/ready command and byte streams.
// Optional `SPI_FLASH_READER_STAT_EN adds stat_cnt, a running count of bytes handed over.
module spi_flash_reader #(
  parameter int DIV = 2,
  parameter int GAP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_adr,
  input  logic [15:0] cmd_len,
  input  logic [1:0]  cmd_iom,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        ss_n,
  output logic        sclk,
  output logic [3:0]  sio_o,
  output logic [3:0]  sio_e,
  input  logic [3:0]  sio_i
`ifdef SPI_FLASH_READER_STAT_EN
  ,
  output logic [31:0] stat_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADR, S_DMY, S_DAT, S_END, S_GAP} state_t;

  state_t      state;
  logic [15:0] div_cnt;
  logic [15:0] gap_cnt;
  logic [4:0]  ph_cnt;
  logic [2:0]  beat_cnt;
  logic [15:0] byte_left;
  logic [1:0]  iom;
  logic [30:0] tx_sr;
  logic [6:0]  rx_sr;

  logic        tick;
  logic        stall;
  logic [7:0]  opcode;
  logic [2:0]  beat_last;
  logic [7:0]  rx_next;
  logic [3:0]  dat_oe;

  always_comb begin
    opcode    = 8'h6B;
    beat_last = 3'd7;
    rx_next   = {rx_sr[6:0], sio_i[1]};
    case (cmd_iom)
      2'd0:    opcode = 8'h03;
      2'd1:    opcode = 8'h0B;
      2'd2:    opcode = 8'h3B;
      default: opcode = 8'h6B;
    endcase
    case (iom)
      2'd3: begin
        beat_last = 3'd1;
        rx_next   = {rx_sr[3:0], sio_i};
      end
      2'd2: begin
        beat_last = 3'd3;
        rx_next   = {rx_sr[5:0], sio_i[1:0]};
      end
      default: ;
    endcase
  end

  assign dat_oe = (iom == 2'd3) ? 4'b0000 : 4'b1100;
  assign tick   = (div_cnt == 16'(DIV - 1));
  // Withhold the byte-completing rising edge while the holding register is still full.
  assign stall  = (state == S_DAT) && !sclk && (beat_cnt == beat_last) && rd_valid && !rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
      ss_n      <= 1'b1;
      sclk      <= 1'b0;
      sio_o     <= '0;
      sio_e     <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      ph_cnt    <= '0;
      beat_cnt  <= '0;
      byte_left <= '0;
      iom       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
    end else begin
      done <= 1'b0;
      if (rd_valid && rd_ready) rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            iom       <= cmd_iom;
            byte_left <= cmd_len;
            div_cnt   <= '0;
            ph_cnt    <= '0;
            beat_cnt  <= '0;
            if (cmd_len == '0) begin
              done    <= 1'b1;
              gap_cnt <= 16'(GAP - 1);
              state   <= S_GAP;
            end else begin
              ss_n  <= 1'b0;
              tx_sr <= {opcode[6:0], cmd_adr};
              sio_o <= {3'b110, opcode[7]};
              sio_e <= 4'b1101;
              state <= S_CMD;
            end
          end
        end
        S_CMD, S_ADR, S_DMY, S_DAT: begin
          if (!tick) begin
            div_cnt <= div_cnt + 16'd1;
          end else if (!stall) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
              if (state == S_DAT) begin
                rx_sr <= rx_next[6:0];
                if (beat_cnt == beat_last) begin
                  beat_cnt  <= '0;
                  rd_data   <= rx_next;
                  rd_valid  <= 1'b1;
                  byte_left <= byte_left - 16'd1;
                end else begin
                  beat_cnt <= beat_cnt + 3'd1;
                end
              end
            end else begin
              sclk     <= 1'b0;
              ph_cnt   <= ph_cnt + 5'd1;
              tx_sr    <= {tx_sr[29:0], 1'b0};
              sio_o[0] <= tx_sr[30];
              case (state)
                S_CMD: if (ph_cnt == 5'd7) begin
                  ph_cnt <= '0;
                  state  <= S_ADR;
                end
                S_ADR: if (ph_cnt == 5'd23) begin
                  ph_cnt <= '0;
                  if (iom == 2'd0) begin
                    sio_o <= dat_oe;
                    sio_e <= dat_oe;
                    state <= S_DAT;
                  end else begin
                    sio_o[0] <= 1'b0;
                    state    <= S_DMY;
                  end
                end
                S_DMY: if (ph_cnt == 5'd7) begin
                  sio_o <= dat_oe;
                  sio_e <= dat_oe;
                  state <= S_DAT;
                end
                S_DAT: if (byte_left == '0) state <= S_END;
                default: ;
              endcase
            end
          end
        end
        S_END: begin
          ss_n    <= 1'b1;
          done    <= 1'b1;
          sio_o   <= '0;
          sio_e   <= '0;
          gap_cnt <= 16'(GAP - 1);
          state   <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SPI_FLASH_READER_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_cnt <= '0;
    else if (rd_valid && rd_ready) stat_cnt <= stat_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI NOR model (mem[i]=i, 1 KiB wrap) plus random consumer.
`timescale 1ns/1ps
module tb_spi_flash_reader;
  localparam int DIV = 2;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [23:0] cmd_adr;
  logic [15:0] cmd_len;
  logic [1:0]  cmd_iom;
  logic        rd_valid, rd_ready;
  logic [7:0]  rd_data;
  logic        done, ss_n, sclk;
  logic [3:0]  sio_o, sio_e, sio_i;
`ifdef SPI_FLASH_READER_STAT_EN
  logic [31:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  spi_flash_reader #(.DIV(DIV), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_iom(cmd_iom),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .ss_n(ss_n), .sclk(sclk),
    .sio_o(sio_o), .sio_e(sio_e), .sio_i(sio_i)
`ifdef SPI_FLASH_READER_STAT_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // flash model state
  logic [7:0]  mem [1024];
  logic [31:0] hdr = '0;
  int rise_cnt = 0, last_rises = 0, hdr_bad = 0, dat_bad = 0, ssn_falls = 0;

  function automatic int op_width(input logic [7:0] op);
    case (op)
      8'h3B:   return 2;
      8'h6B:   return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int op_dstart(input logic [7:0] op);
    return (op == 8'h03) ? 32 : 40;
  endfunction

  always @(negedge ss_n) begin
    rise_cnt = 0;
    hdr      = '0;
    hdr_bad  = 0;
    dat_bad  = 0;
    ssn_falls++;
  end

  always @(posedge ss_n) last_rises = rise_cnt;

  always @(posedge sclk) if (!ss_n) begin
    if (rise_cnt < 32) begin
      hdr = {hdr[30:0], sio_o[0]};
      if (sio_e !== 4'b1101 || sio_o[3:2] !== 2'b11) hdr_bad++;
    end else if (rise_cnt < op_dstart(hdr[31:24])) begin
      if (sio_e !== 4'b1101 || sio_o[0] !== 1'b0) hdr_bad++;
    end else begin
      if (sio_e !== ((hdr[31:24] == 8'h6B) ? 4'b0000 : 4'b1100)) dat_bad++;
    end
    rise_cnt++;
  end

  // Mode 0: the flash shifts its next data chunk out on each falling edge after the header.
  always @(negedge sclk) if (!ss_n && rise_cnt >= op_dstart(hdr[31:24])) begin
    int w, k, bp;
    logic [7:0] b, ch;
    w  = op_width(hdr[31:24]);
    k  = rise_cnt - op_dstart(hdr[31:24]);
    bp = k * w;
    b  = mem[(int'(hdr[23:0]) + bp / 8) % 1024];
    ch = (b >> (8 - w - bp % 8)) & 8'((1 << w) - 1);
    case (w)
      1:       sio_i = {2'b00, ch[0], 1'b0};
      2:       sio_i = {2'b00, ch[1:0]};
      default: sio_i = ch[3:0];
    endcase
  end

  // consumer, done counter and inter-transaction gap monitor
  logic [7:0] got[$];
  int  handed = 0, done_cnt = 0, hi_run = 0;
  bit  gap_armed = 0, stall_mode = 0, stall_on = 0, stall_done = 0;
  int  stall_cyc = 0, rises_mark = 0;

  always @(negedge clk) begin
    if (stall_mode) begin
      if (!stall_on && !stall_done && rd_valid) begin
        stall_on  = 1;
        stall_cyc = 0;
        rd_ready  = 1'b0;
      end else if (stall_on) begin
        stall_cyc++;
        if (stall_cyc == 45) rises_mark = rise_cnt;
        if (stall_cyc == 49) begin
          check_eq("stall_sclk_low", 32'(sclk), 0);
          check_eq("stall_ssn_low", 32'(ss_n), 0);
          check_eq("stall_frozen", rise_cnt, rises_mark);
        end
        if (stall_cyc == 50) begin
          stall_on   = 0;
          stall_done = 1;
          rd_ready   = 1'b1;
        end
      end
    end else begin
      rd_ready = ($urandom_range(3) != 0);
    end
    if (rd_valid && rd_ready) begin
      got.push_back(rd_data);
      handed++;
    end
    if (done) done_cnt++;
    if (ss_n) hi_run++;
    else begin
      if (gap_armed && hi_run > 0) check_eq("ss_gap_min", 32'(hi_run >= GAP), 1);
      hi_run    = 0;
      gap_armed = 1;
    end
  end

  task automatic run_txn(input logic [23:0] adr, input logic [15:0] len, input logic [1:0] iom,
                         input string nm);
    int t, w, exp_sclk, d0, f0, n;
    logic [7:0] exp_op;
    case (iom)
      2'd0:    exp_op = 8'h03;
      2'd1:    exp_op = 8'h0B;
      2'd2:    exp_op = 8'h3B;
      default: exp_op = 8'h6B;
    endcase
    w        = (iom == 2'd3) ? 4 : (iom == 2'd2) ? 2 : 1;
    exp_sclk = 32 + ((iom != 2'd0) ? 8 : 0) + int'(len) * 8 / w;
    got.delete();
    d0 = done_cnt;
    f0 = ssn_falls;
    t  = 0;
    while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
    check_eq({nm, "_ready"}, 32'(cmd_ready), 1);
    cmd_adr = adr; cmd_len = len; cmd_iom = iom; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq({nm, "_done_next"}, 32'(done), 32'(len == 0));
    check_eq({nm, "_ssn_next"}, 32'(ss_n), 32'(len == 0));
    if (len == 0) begin
      t = 0;
      while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
      check_eq({nm, "_gap_ready"}, 32'(t >= GAP && t <= GAP + 2), 1);
      check_eq({nm, "_no_ss"}, ssn_falls, f0);
      check_eq({nm, "_done_pulses"}, done_cnt - d0, 1);
    end else begin
      check_eq({nm, "_mosi_op7"}, 32'(sio_o[0]), 32'(exp_op[7]));
      t = 1;
      @(negedge clk);
      while (!sclk && t < 100) begin t++; @(negedge clk); end
      check_eq({nm, "_first_rise"}, t, DIV);
      t = 0;
      while (done_cnt == d0 && t < 20000) begin @(negedge clk); t++; end
      check_eq({nm, "_done_seen"}, 32'(done_cnt != d0), 1);
      t = 0;
      while (got.size() < int'(len) && t < 2000) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      check_eq({nm, "_done_pulses"}, done_cnt - d0, 1);
      check_eq({nm, "_ssn_end"}, 32'(ss_n), 1);
      check_eq({nm, "_opcode"}, 32'(hdr[31:24]), 32'(exp_op));
      check_eq({nm, "_adr"}, 32'(hdr[23:0]), 32'(adr));
      check_eq({nm, "_sclks"}, last_rises, exp_sclk);
      check_eq({nm, "_hdr_pins"}, hdr_bad, 0);
      check_eq({nm, "_dat_oe"}, dat_bad, 0);
      check_eq({nm, "_nbytes"}, got.size(), 32'(len));
      n = (got.size() < int'(len)) ? got.size() : int'(len);
      for (int i = 0; i < n; i++)
        check_eq({nm, "_byte"}, 32'(got[i]), 32'(mem[(int'(adr) + i) % 1024]));
    end
`ifdef SPI_FLASH_READER_STAT_EN
    check_eq({nm, "_stat"}, stat_cnt, handed);
`endif
  endtask

  initial begin
    int t;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    cmd_valid = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_iom = '0;
    rd_ready = 1'b1; sio_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ss_n", 32'(ss_n), 1);
    check_eq("rst_sclk", 32'(sclk), 0);
    check_eq("rst_sio_o", 32'(sio_o), 0);
    check_eq("rst_sio_e", 32'(sio_e), 0);
    check_eq("rst_rd_valid", 32'(rd_valid), 0);
    check_eq("rst_rd_data", 32'(rd_data), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 0);
    rst_n = 1'b1;

    run_txn(24'h000010, 16'd4, 2'd0, "read03");
    run_txn(24'h000010, 16'd4, 2'd3, "read6b");
    run_txn(24'h0003FE, 16'd4, 2'd2, "read3b_wrap");

    stall_on = 0; stall_done = 0; rd_ready = 1'b1; stall_mode = 1;
    run_txn(24'h000020, 16'd3, 2'd1, "read0b_stall");
    check_eq("stall_happened", 32'(stall_done), 1);
    stall_mode = 0;

    run_txn(24'h000040, 16'd0, 2'd1, "len0");

    // abort in the address phase
    t = 0;
    while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
    cmd_adr = 24'h000055; cmd_len = 16'd4; cmd_iom = 2'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (rise_cnt < 16 && t < 1000) begin @(negedge clk); t++; end
    check_eq("abort_in_adr", 32'(rise_cnt >= 16 && rise_cnt < 32), 1);
    t = done_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("abort_ss_n", 32'(ss_n), 1);
    check_eq("abort_sclk", 32'(sclk), 0);
    check_eq("abort_sio_e", 32'(sio_e), 0);
    gap_armed = 0;
    handed = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("abort_no_done", done_cnt, t);
    run_txn(24'h000100, 16'd2, 2'd0, "post_abort");

    for (int i = 0; i < 12; i++)
      run_txn(24'($urandom()), 16'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), "rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
